// File: rtl/montgomery_exp_ctrl.sv
// ---------------------------------------------------------------------------
// montgomery_exp_ctrl
//   Computes X^E mod M by left-to-right square-and-multiply. Every step is one
//   multiplication issued to an external Montgomery multiplier through a
//   start/done handshake. The controller waits for each product before it
//   issues the next step.
//
//   Optional feature macro: MONT_EXP_FROMMONT_EN
//     defined   : one extra multiplication mult(acc, 1) runs before the result
//                 is published, so result is plain X^E mod M.
//     undefined : result stays in Montgomery form (X^E * R mod M).
//
// Ports
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   start        : 1-cycle request, accepted only in IDLE or DONE
//   in_x         : base in Montgomery form
//   in_one       : R mod M (Montgomery one)
//   in_m         : odd modulus
//   in_e         : exponent
//   in_e_len     : number of exponent bits used (clamped to EXP_WIDTH)
//   mult_start   : 1-cycle pulse to the multiplier
//   mult_a/b/m   : multiplier operands, held stable until its done is seen
//   mult_result  : multiplier product a*b*R^-1 mod m
//   mult_done    : multiplier completion level
//   result       : final value, held until the next accepted start
//   done         : high from completion until the next accepted start
// ---------------------------------------------------------------------------
module montgomery_exp_ctrl #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [WIDTH-1:0]               in_x,
  input  logic [WIDTH-1:0]               in_one,
  input  logic [WIDTH-1:0]               in_m,
  input  logic [EXP_WIDTH-1:0]           in_e,
  input  logic [$clog2(EXP_WIDTH+1)-1:0] in_e_len,
  output logic                           mult_start,
  output logic [WIDTH-1:0]               mult_a,
  output logic [WIDTH-1:0]               mult_b,
  output logic [WIDTH-1:0]               mult_m,
  input  logic [WIDTH-1:0]               mult_result,
  input  logic                           mult_done,
  output logic [WIDTH-1:0]               result,
  output logic                           done
);

  localparam int CW = $clog2(EXP_WIDTH + 1);
  localparam logic [CW-1:0] LEN_MAX = CW'(EXP_WIDTH);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SQR_REQ,
    ST_SQR_WAIT,
    ST_MUL_REQ,
    ST_MUL_WAIT,
`ifdef MONT_EXP_FROMMONT_EN
    ST_CONV_REQ,
    ST_CONV_WAIT,
`endif
    ST_FIN,
    ST_DONE
  } state_t;

  // State entered once the last exponent bit has been processed.
`ifdef MONT_EXP_FROMMONT_EN
  localparam state_t OPS_END = ST_CONV_REQ;
`else
  localparam state_t OPS_END = ST_FIN;
`endif

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     x_reg, x_next;
  logic [WIDTH-1:0]     m_reg, m_next;
  logic [EXP_WIDTH-1:0] e_reg, e_next;
  logic [CW-1:0]        i_reg, i_next;
  logic [WIDTH-1:0]     acc_reg, acc_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  logic [WIDTH-1:0]     b_reg, b_next;
  logic [WIDTH-1:0]     result_reg, result_next;
  logic                 done_reg, done_next;
  logic                 wait_first_reg, wait_first_next;

  logic [CW-1:0]        len_clamped;
  logic                 e_bit;

  assign len_clamped = (in_e_len > LEN_MAX) ? LEN_MAX : in_e_len;
  // Exponent bit at the (already decremented) bit counter.
  assign e_bit       = |(e_reg & (EXP_WIDTH'(1) << i_reg));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      x_reg          <= '0;
      m_reg          <= '0;
      e_reg          <= '0;
      i_reg          <= '0;
      acc_reg        <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      result_reg     <= '0;
      done_reg       <= 1'b0;
      wait_first_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      x_reg          <= x_next;
      m_reg          <= m_next;
      e_reg          <= e_next;
      i_reg          <= i_next;
      acc_reg        <= acc_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      result_reg     <= result_next;
      done_reg       <= done_next;
      wait_first_reg <= wait_first_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    x_next          = x_reg;
    m_next          = m_reg;
    e_next          = e_reg;
    i_next          = i_reg;
    acc_next        = acc_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    result_next     = result_reg;
    done_next       = done_reg;
    wait_first_next = wait_first_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          x_next     = in_x;
          m_next     = in_m;
          e_next     = in_e;
          i_next     = len_clamped;
          acc_next   = in_one;
          done_next  = 1'b0;
          state_next = (len_clamped != '0) ? ST_SQR_REQ : OPS_END;
        end
      end
      ST_SQR_REQ: begin
        i_next          = i_reg - CW'(1);
        wait_first_next = 1'b1;
        state_next      = ST_SQR_WAIT;
      end
      ST_SQR_WAIT: begin
        // The first wait cycle is skipped so a done level left over from the
        // previous product cannot be mistaken for this one.
        if (wait_first_reg) begin
          wait_first_next = 1'b0;
        end else if (mult_done) begin
          acc_next = mult_result;
          if (e_bit)
            state_next = ST_MUL_REQ;
          else
            state_next = (i_reg != '0) ? ST_SQR_REQ : OPS_END;
        end
      end
      ST_MUL_REQ: begin
        wait_first_next = 1'b1;
        state_next      = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        if (wait_first_reg) begin
          wait_first_next = 1'b0;
        end else if (mult_done) begin
          acc_next   = mult_result;
          state_next = (i_reg != '0) ? ST_SQR_REQ : OPS_END;
        end
      end
`ifdef MONT_EXP_FROMMONT_EN
      ST_CONV_REQ: begin
        wait_first_next = 1'b1;
        state_next      = ST_CONV_WAIT;
      end
      ST_CONV_WAIT: begin
        if (wait_first_reg) begin
          wait_first_next = 1'b0;
        end else if (mult_done) begin
          acc_next   = mult_result;
          state_next = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        result_next = acc_reg;
        done_next   = 1'b1;
        state_next  = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Operands are loaded on the edge that enters a request state so they are
    // already valid during the pulse cycle and stay put through the wait.
    if (state_next != state_reg) begin
      case (state_next)
        ST_SQR_REQ: begin
          a_next = acc_next;
          b_next = acc_next;
        end
        ST_MUL_REQ: begin
          a_next = acc_next;
          b_next = x_reg;
        end
`ifdef MONT_EXP_FROMMONT_EN
        ST_CONV_REQ: begin
          a_next = acc_next;
          b_next = WIDTH'(1);
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef MONT_EXP_FROMMONT_EN
  assign mult_start = (state_reg == ST_SQR_REQ) || (state_reg == ST_MUL_REQ) ||
                      (state_reg == ST_CONV_REQ);
`else
  assign mult_start = (state_reg == ST_SQR_REQ) || (state_reg == ST_MUL_REQ);
`endif

  assign mult_a = a_reg;
  assign mult_b = b_reg;
  assign mult_m = m_reg;
  assign result = result_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
module tb_montgomery_exp_ctrl;

  localparam int W  = 8;
  localparam int EW = 8;
  localparam int CW = $clog2(EW + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  in_x, in_one, in_m;
  logic [EW-1:0] in_e;
  logic [CW-1:0] in_e_len;
  logic          mult_start;
  logic [W-1:0]  mult_a, mult_b, mult_m;
  logic [W-1:0]  mult_result;
  logic          mult_done;
  logic [W-1:0]  result;
  logic          done;

  montgomery_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_x       (in_x),
    .in_one     (in_one),
    .in_m       (in_m),
    .in_e       (in_e),
    .in_e_len   (in_e_len),
    .mult_start (mult_start),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_m     (mult_m),
    .mult_result(mult_result),
    .mult_done  (mult_done),
    .result     (result),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int np;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  // ---------------- reference arithmetic ----------------
  function automatic int rinv(input int m);
    for (int r = 1; r < m; r++)
      if ((256 * r) % m == 1) return r;
    return 0;
  endfunction

  function automatic int modpow(input int b, input int e, input int m);
    int r;
    r = 1 % m;
    for (int k = 0; k < e; k++) r = (r * b) % m;
    return r;
  endfunction

  function automatic int popc(input int v);
    int c;
    c = 0;
    for (int k = 0; k < 32; k++) c += (v >> k) & 1;
    return c;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // ---------------- multiplier model ----------------
  initial begin : mult_model
    int busy, cnt, ca, cb, cm;
    busy = 0; cnt = 0; ca = 0; cb = 0; cm = 1;
    mult_done   = 1'b0;
    mult_result = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0;
        mult_done = 1'b0;
      end else if (mult_start) begin
        pulses++;
        ca = int'(mult_a); cb = int'(mult_b); cm = int'(mult_m);
        busy = 1;
        cnt  = $urandom_range(3, 20);
        mult_done = 1'b0;
      end else if (busy != 0) begin
        check("operand_stable", int'({mult_a, mult_b, mult_m}), (ca << 16) | (cb << 8) | cm);
        cnt--;
        if (cnt == 0) begin
          mult_result = W'((ca * cb % cm) * rinv(cm) % cm);
          mult_done   = 1'b1;
          busy        = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic prev;
    exp_t ex;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (done && !prev) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got result %0d expected no completion", result);
          end else begin
            ex = q.pop_front();
            check("result", int'(result), ex.res);
            check("pulse_count", pulses, ex.np);
            $display("done: result=%0d pulses=%0d (want %0d/%0d)", result, pulses, ex.res, ex.np);
          end
        end
        prev = done;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_op(input int x, input int m, input int e, input int len);
    int lc, ee, xp, plain;
    exp_t ex;
    lc    = (len > EW) ? EW : len;
    ee    = e & ((1 << lc) - 1);
    xp    = (x * rinv(m)) % m;
    plain = modpow(xp, ee, m);
`ifdef MONT_EXP_FROMMONT_EN
    ex.res = plain;
    ex.np  = lc + popc(ee) + 1;
`else
    ex.res = (plain * 256) % m;
    ex.np  = lc + popc(ee);
`endif
    @(negedge clk);
    pulses   = 0;
    in_x     = W'(x);
    in_one   = W'(256 % m);
    in_m     = W'(m);
    in_e     = EW'(e);
    in_e_len = CW'(len);
    start    = 1'b1;
    q.push_back(ex);
    $display("start: x=%0d m=%0d e=0x%0h len=%0d -> expect result=%0d pulses=%0d",
             x, m, e, len, ex.res, ex.np);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  task automatic wait_pulses(input int target);
    int n;
    n = 0;
    while (pulses < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("pulse_wait", pulses, target);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got simulation hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; start = 1'b0;
    in_x = '0; in_one = '0; in_m = '0; in_e = '0; in_e_len = '0;
    repeat (3) @(negedge clk);
    check("rst_mult_start", int'(mult_start), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_operands", int'({mult_a, mult_b, mult_m}), 0);
    reset = 1'b0;

    // Directed cases
    issue_op(5, 13, 5, 3);
    wait_done();

    issue_op(5, 13, 5, 0);
`ifndef MONT_EXP_FROMMONT_EN
    // Start accepted on the edge after issue; done must follow one cycle later.
    check("len0_done_early", int'(done), 0);
    @(negedge clk);
    check("len0_done_latency", int'(done), 1);
`endif
    wait_done();

    issue_op(5, 13, 8'hFF, 8);
    wait_done();
    issue_op(5, 13, 8'hF5, 3);
    wait_done();
    issue_op(7, 29, 8'hA7, 15);     // length clamped to 8
    wait_done();

    // Randomized
    for (int k = 0; k < 20; k++) begin
      int m;
      m = $urandom_range(1, 127) * 2 + 1;
      issue_op($urandom_range(0, m - 1), m, $urandom_range(0, 255), $urandom_range(0, 10));
      wait_done();
    end

    // Start during SQR_WAIT must be ignored
    issue_op(5, 13, 5, 3);
    wait_pulses(1);
    @(negedge clk);
    in_x = 8'd7; in_m = 8'd29; in_one = 8'd24; in_e = 8'hFF; in_e_len = 4'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset while in MUL_WAIT (second operation of e=101 is the multiply)
    issue_op(5, 13, 5, 3);
    wait_pulses(2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_mult_start", int'(mult_start), 0);
    check("midrst_done", int'(done), 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("midrst_result", int'(result), 0);
    issue_op(5, 13, 5, 3);
    wait_done();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
